// File: rtl/serial_rx_if.sv
// Byte hand-off channel between serial_rx (master side) and its consumer (slave side).
// The master holds rx_data/rx_valid until the slave raises rx_ready.
interface serial_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/serial_rx.sv
// UART receiver: 8N1 by default, 8E1 when SERIAL_RX_PARITY_EN is defined.
// Mid-bit sampling from a DIV-cycle bit counter; one-byte holding register with sticky overrun.
module serial_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_in,
    serial_rx_if.master  bus,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun,
    output logic         parity_err
);

    localparam int DIV = (CLK_HZ + (BAUD / 2)) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((DIV / 2) - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    logic [1:0]    sync_r;
    logic          rx_s;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shift_r, shift_s;
    logic          load_s, ferr_s, perr_s;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous line; resets to idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], serial_in};
        end
    end

    // FSM state, bit counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
        end
    end

    // Next-state logic; sample strobes fire when the counter reaches its wrap value.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        load_s  = 1'b0;
        ferr_s  = 1'b0;
        perr_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_s = '0;
                if (!rx_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_s = '0;
                    bit_s = 3'd0;
                    if (!rx_s) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {rx_s, shift_r[7:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    perr_s  = parity_bad(shift_r, rx_s);
                    state_s = S_STOP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    state_s = S_IDLE;
                    if (rx_s) begin
                        load_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = '0;
                bit_s   = 3'd0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            busy       <= (state_s != S_IDLE);
            frame_err  <= ferr_s;
            parity_err <= perr_s;
        end
    end

    // Holding register: a load wins over an accept; a load into a full, unaccepted slot is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rx_data  <= 8'h00;
            bus.rx_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (load_s) begin
            if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shift_r;
                bus.rx_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed scenarios plus randomized frames,
// compared every cycle against an event-scheduled model of the expected outputs.
module tb_serial_rx;

    localparam int CLK_HZ = 2000;
    localparam int BAUD   = 100;
    localparam int DIV    = 20;
    localparam int H      = DIV / 2;
`ifdef SERIAL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB  = 10 + P;
    localparam int LAT = 3 + H + (9 + P) * DIV;

    localparam int EV_BON  = 0;
    localparam int EV_BOFF = 1;
    localparam int EV_LOAD = 2;
    localparam int EV_FERR = 3;
    localparam int EV_PERR = 4;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_in;
    logic rx_ready;
    logic busy, frame_err, overrun, parity_err;

    serial_rx_if bus ();
    assign bus.rx_ready = rx_ready;

    serial_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .bus        (bus),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_k = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   busy_cnt = 0;
    logic chk_en = 1'b0;
    logic rand_ready = 1'b0;
    ev_t  evq[$];

    logic       m_busy = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       ld;
    logic [7:0] ld_d;
    logic [12:0] exp_v, act_v;

    function automatic logic par_of(input logic [7:0] d);
        return ^d;
    endfunction

    // Model: apply the events due at this edge, then the holding-register rules.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_data = 8'h00;
            m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            evq.delete();
        end else begin
            ld = 1'b0; ld_d = 8'h00; m_ferr = 1'b0; m_perr = 1'b0;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].due == cyc) begin
                    case (evq[i].kind)
                        EV_BON:  m_busy = 1'b1;
                        EV_BOFF: m_busy = 1'b0;
                        EV_LOAD: begin ld = 1'b1; ld_d = evq[i].data; end
                        EV_FERR: m_ferr = 1'b1;
                        EV_PERR: m_perr = 1'b1;
                        default: ;
                    endcase
                    evq.delete(i);
                end
            end
            if (ld) begin
                if (!m_valid || rx_ready) begin
                    m_data = ld_d; m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare all outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = reset ? {m_busy, m_valid, m_data, m_ferr, m_ovr, m_perr} : 13'd0;
            act_v = {busy, bus.rx_valid, bus.rx_data, frame_err, overrun, parity_err};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d busy/valid/data/ferr/ovr/perr got %b/%b/%h/%b/%b/%b expected %b/%b/%h/%b/%b/%b",
                         cyc, act_v[12], act_v[11], act_v[10:3], act_v[2], act_v[1], act_v[0],
                         exp_v[12], exp_v[11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            if (reset) begin
                if (frame_err === 1'b1)  ferr_cnt++;
                if (parity_err === 1'b1) perr_cnt++;
                if (busy === 1'b1)       busy_cnt++;
            end
        end
    end

    // Random consumer back-pressure for the randomized phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) rx_ready = ($urandom_range(0, 3) == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int gap);
        logic [10:0] fr;
        int k, e;
        @(posedge clk); #1;
        k = cyc; last_k = k; e = k + LAT;
`ifdef SERIAL_RX_PARITY_EN
        fr = {stop, par, d, 1'b0};
        if (par != par_of(d)) evq.push_back('{due: k + 3 + H + 9 * DIV, kind: EV_PERR, data: 8'h00});
`else
        fr = {par, stop, d, 1'b0};
`endif
        evq.push_back('{due: k + 3, kind: EV_BON, data: 8'h00});
        evq.push_back('{due: e, kind: EV_BOFF, data: 8'h00});
        if (stop) begin
            evq.push_back('{due: e, kind: EV_LOAD, data: d});
        end else begin
            // The low stop bit is still on the line when the FSM goes idle: a short false start follows.
            evq.push_back('{due: e, kind: EV_FERR, data: 8'h00});
            evq.push_back('{due: e + 1, kind: EV_BON, data: 8'h00});
            evq.push_back('{due: e + 1 + H, kind: EV_BOFF, data: 8'h00});
        end
        for (int i = 0; i < NB; i++) begin
            serial_in = fr[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        serial_in = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic glitch(input int len);
        int k;
        @(posedge clk); #1;
        k = cyc;
        evq.push_back('{due: k + 3, kind: EV_BON, data: 8'h00});
        evq.push_back('{due: k + 3 + H, kind: EV_BOFF, data: 8'h00});
        serial_in = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (H + DIV) @(posedge clk);
    endtask

    task automatic pulse_ready_at(input int edge_n);
        do begin
            @(posedge clk); #1;
        end while (cyc < edge_n);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b0;
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int f0, p0, b0, k1, e2, len;
        logic [7:0] d;
        logic st, pb;
        serial_in = 1'b1;
        rx_ready = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        #2;
        check("reset_state", {3'b000, busy, bus.rx_valid, bus.rx_data, frame_err, overrun, parity_err}, 16'h0000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);

        send_frame(8'h55, 1'b1, par_of(8'h55), DIV);
        sample();
        check("rx55_valid", {15'd0, bus.rx_valid}, 16'd1);
        check("rx55_data", {8'd0, bus.rx_data}, 16'h0055);
        check("rx55_ferr_ovr", {14'd0, frame_err, overrun}, 16'd0);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        sample();
        check("accept_clears_valid", {15'd0, bus.rx_valid}, 16'd0);

        f0 = ferr_cnt; b0 = busy_cnt;
        glitch(H - 3);
        sample();
        check("glitch_busy_cycles", 16'(busy_cnt - b0), 16'(H));
        check("glitch_no_valid_ferr", {14'd0, bus.rx_valid, 1'b0} | 16'(ferr_cnt - f0), 16'd0);

        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0, par_of(8'hA3), DIV);
        sample();
        check("a3_ferr_pulses", 16'(ferr_cnt - f0), 16'd1);
        check("a3_no_valid", {15'd0, bus.rx_valid}, 16'd0);

        send_frame(8'h12, 1'b1, par_of(8'h12), 0);
        send_frame(8'h34, 1'b1, par_of(8'h34), DIV);
        sample();
        check("b2b_keep_old", {8'd0, bus.rx_data}, 16'h0012);
        check("b2b_overrun", {15'd0, overrun}, 16'd1);

        do_reset(3);
        send_frame(8'h12, 1'b1, par_of(8'h12), 0);
        k1 = last_k;
        e2 = k1 + NB * DIV + 1 + LAT;
        fork
            send_frame(8'h34, 1'b1, par_of(8'h34), DIV);
            pulse_ready_at(e2 - 1);
        join
        sample();
        check("b2b_ready_data", {8'd0, bus.rx_data}, 16'h0034);
        check("b2b_ready_valid_ovr", {14'd0, bus.rx_valid, overrun}, 16'b10);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;

        @(posedge clk); #1;
        evq.push_back('{due: cyc + 3, kind: EV_BON, data: 8'h00});
        serial_in = 1'b0;
        repeat (DIV) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (4 * DIV) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        check("midframe_reset_outputs", {3'b000, busy, bus.rx_valid, bus.rx_data, frame_err, overrun, parity_err}, 16'h0000);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        repeat (DIV) @(posedge clk);
        sample();
        check("after_reset_idle", {14'd0, busy, bus.rx_valid}, 16'd0);
        send_frame(8'h0F, 1'b1, par_of(8'h0F), DIV);
        sample();
        check("after_reset_0f", {7'd0, bus.rx_valid, bus.rx_data}, 16'h010F);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;

`ifdef SERIAL_RX_PARITY_EN
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0, DIV);
        sample();
        check("par_bad_pulse", 16'(perr_cnt - p0), 16'd1);
        check("par_bad_loaded", {7'd0, bus.rx_valid, bus.rx_data}, 16'h0107);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, DIV);
        sample();
        check("par_good_no_pulse", 16'(perr_cnt - p0), 16'd0);
`else
        p0 = perr_cnt;
`endif

        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                len = $urandom_range(1, H - 2);
                glitch(len);
            end
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 7) != 0);
            pb = ($urandom_range(0, 3) == 0) ? ~par_of(d) : par_of(d);
            send_frame(d, st, pb, st ? $urandom_range(0, DIV) : DIV + $urandom_range(0, DIV));
        end
        @(posedge clk); #3;
        rand_ready = 1'b0;
        rx_ready = 1'b0;
        repeat (2 * DIV) @(posedge clk);
`ifndef SERIAL_RX_PARITY_EN
        sample();
        check("no_parity_pulses", 16'(perr_cnt - p0), 16'd0);
`endif
        sample();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
